// File: rtl/free_list_ctrl_pkg.sv
// Shared types and sizing for the physical-register free list.
// Pure definitions, no logic or latency.
// No flow control; consumers import the types they need.
package free_list_ctrl_pkg;

  localparam int NUM_A_REGS    = 32;
  localparam int ROB_SIZE      = 16;
  localparam int NUM_P_REGS    = ROB_SIZE + NUM_A_REGS;
  localparam int MAX_FREE_REGS = ROB_SIZE;
  localparam int PRN_WIDTH     = $clog2(NUM_P_REGS);
  localparam int F_LIST_WDTH   = $clog2(MAX_FREE_REGS);

  typedef logic [PRN_WIDTH-1:0]   prn_t;
  typedef logic [F_LIST_WDTH-1:0] free_list_ptr;
  // One bit wider than the pointer so a completely full list (16) is representable.
  typedef logic [F_LIST_WDTH:0]   fl_count_t;

  typedef enum logic {
    FL_INIT = 1'b0,
    FL_RUN  = 1'b1
  } fl_state_t;

  // Architectural-mapped registers must never come back to the free list.
  function automatic logic is_arch_prn(prn_t prn);
    return prn < prn_t'(NUM_A_REGS);
  endfunction

endpackage

// File: rtl/fl_push_arb.sv
// Fixed-priority (squash over commit) arbiter for the single free-list push port.
// Latency: fully combinational, zero cycles.
// Backpressure: both readies drop when there is no space; commit also yields to a valid squash.
//
// Ports:
//   space              - push slot available this cycle (list not full, or a pop frees one)
//   squash_valid/prn   - squash-walk release request, highest priority
//   commit_valid/prn   - commit-time release request
//   squash_ready       - squash push accepted when valid
//   commit_ready       - commit push accepted when valid
//   push_fire/push_prn - the one push (if any) taking place this cycle
module fl_push_arb
  import free_list_ctrl_pkg::*;
(
  input  logic space,
  input  logic squash_valid,
  input  prn_t squash_prn,
  input  logic commit_valid,
  input  prn_t commit_prn,
  output logic squash_ready,
  output logic commit_ready,
  output logic push_fire,
  output prn_t push_prn
);

  assign squash_ready = space;
  assign commit_ready = space && !squash_valid;

  assign push_fire = (squash_valid && squash_ready) || (commit_valid && commit_ready);
  assign push_prn  = squash_valid ? squash_prn : commit_prn;

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free list: LIFO init after reset, one rename pop and one release push per cycle.
// Latency: pop data combinational (zero cycles); count/push take effect at the next clock edge.
// Backpressure: alloc_gnt low when empty/recovering; release readies low when full with no pop.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   alloc_req/gnt/prn    - rename allocation request, grant, granted prn (0 when not granted)
//   commit_free_*        - commit release of p_old (valid/ready handshake)
//   squash_free_*        - squash release of p_new (valid/ready handshake, wins over commit)
//   recover              - squash recovery in progress; blocks allocation only
//   free_count           - entries currently on the list (0..16)
//   init_done            - list initialised and running
//   err_bad_prn          - sticky: an architectural prn (< NUM_A_REGS) was pushed
module free_list_ctrl
  import free_list_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [PRN_WIDTH-1:0] alloc_prn,
  input  logic                 commit_free_valid,
  input  logic [PRN_WIDTH-1:0] commit_free_prn,
  output logic                 commit_free_ready,
  input  logic                 squash_free_valid,
  input  logic [PRN_WIDTH-1:0] squash_free_prn,
  output logic                 squash_free_ready,
  input  logic                 recover,
  output logic [F_LIST_WDTH:0] free_count,
  output logic                 init_done,
  output logic                 err_bad_prn
);

  fl_state_t    state;
  fl_state_t    state_nxt;
  fl_count_t    count;
  fl_count_t    count_nxt;
  free_list_ptr init_idx;
  prn_t         list [MAX_FREE_REGS];
  logic         err;

  logic         run;
  logic         pop_fire;
  logic         space;
  logic         push_fire;
  prn_t         push_prn;
  free_list_ptr top_idx;
  free_list_ptr wr_idx;

  // Handshakes are suppressed while reset is asserted so nothing is accepted
  // in a cycle whose state update the reset is about to discard.
  assign run = (state == FL_RUN) && rst_n;

  assign top_idx  = free_list_ptr'(count - fl_count_t'(1));
  assign pop_fire = run && alloc_req && !recover && (count != '0);

  assign alloc_gnt = pop_fire;
  assign alloc_prn = pop_fire ? list[top_idx] : '0;

  // A same-cycle pop vacates the top slot, so a full list can still take a push.
  assign space = run && ((count < fl_count_t'(MAX_FREE_REGS)) || pop_fire);

  // With a simultaneous pop the push overwrites the slot being popped;
  // otherwise it lands just above the current top.
  assign wr_idx = pop_fire ? top_idx : free_list_ptr'(count);

  fl_push_arb u_push_arb (
    .space        (space),
    .squash_valid (squash_free_valid),
    .squash_prn   (squash_free_prn),
    .commit_valid (commit_free_valid),
    .commit_prn   (commit_free_prn),
    .squash_ready (squash_free_ready),
    .commit_ready (commit_free_ready),
    .push_fire    (push_fire),
    .push_prn     (push_prn)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      FL_INIT: begin
        count_nxt = fl_count_t'(init_idx) + fl_count_t'(1);
        if (init_idx == free_list_ptr'(MAX_FREE_REGS - 1)) begin
          state_nxt = FL_RUN;
        end
      end
      FL_RUN: begin
        count_nxt = count + fl_count_t'(push_fire) - fl_count_t'(pop_fire);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FL_INIT;
      count    <= '0;
      init_idx <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (state == FL_INIT) begin
        list[init_idx] <= prn_t'(NUM_A_REGS) + prn_t'(init_idx);
        init_idx       <= init_idx + free_list_ptr'(1);
      end
      if (push_fire) begin
        // Bad entries are still stored; the flag is only for visibility.
        list[wr_idx] <= push_prn;
        if (is_arch_prn(push_prn)) begin
          err <= 1'b1;
        end
      end
    end
  end

  assign free_count  = count;
  assign init_done   = (state == FL_RUN);
  assign err_bad_prn = err;

endmodule
